// File: rtl/pe_sequencer.sv
// Host-side driver for one processing element: takes a cell job, walks the PE through
// enable -> done -> advance, and returns its result. Optional watchdog: `PE_SEQ_TIMEOUT_EN.
module pe_sequencer #(
  parameter int COUNT_W        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [447:0]       in_probs,
  input  logic [383:0]       in_vals,
  input  logic [63:0]        in_prior,
  output logic               pe_enable,
  output logic               pe_advance,
  input  logic               pe_done,
  output logic [447:0]       pe_probs,
  output logic [383:0]       pe_vals,
  output logic [63:0]        pe_prior,
  input  logic [383:0]       pe_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [191:0]       out_vals,
  output logic [COUNT_W-1:0] jobs_done,
  output logic               timeout_err
);

  typedef enum logic [2:0] {IDLE, RUN, ADV, SETTLE, HOLD} state_t;

  state_t state, next_state;
  logic   next_enable, next_advance, next_out_valid;
  logic   timeout_hit;

  // Only pe_vals_out[0] is returned; the rest of the PE result bus is intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{pe_result[383:192], 32'(TIMEOUT_CYCLES)};

  assign in_ready = (state == IDLE);

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] run_cnt;

  assign timeout_hit = (state == RUN) && !pe_done &&
                       (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // RUN can only be entered from IDLE, so clearing while idle covers the entry clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == RUN) run_cnt <= run_cnt + CNT_W'(1);
      else              run_cnt <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN: begin
        if (pe_done)          next_state = ADV;
        else if (timeout_hit) next_state = IDLE;
      end
      ADV:     next_state = SETTLE;
      SETTLE:  next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Strobes are decoded from the next state so they come straight out of flops.
    next_enable    = (next_state == RUN);
    next_advance   = (next_state == ADV);
    next_out_valid = (next_state == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pe_enable  <= 1'b0;
      pe_advance <= 1'b0;
      out_valid  <= 1'b0;
      out_vals   <= '0;
      jobs_done  <= '0;
      pe_probs   <= '0;
      pe_vals    <= '0;
      pe_prior   <= '0;
    end else begin
      state      <= next_state;
      pe_enable  <= next_enable;
      pe_advance <= next_advance;
      out_valid  <= next_out_valid;
      if (state == IDLE && in_valid) begin
        pe_probs <= in_probs;
        pe_vals  <= in_vals;
        pe_prior <= in_prior;
      end
      if (state == SETTLE) out_vals <= pe_result[191:0];
      if (state == HOLD && out_ready) jobs_done <= jobs_done + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized bench for pe_sequencer: a cycle-level PE model plus a job scoreboard.
// Timeout scenario is compiled in when PE_SEQ_TIMEOUT_EN is defined.
module tb_pe_sequencer;
  localparam int COUNT_W = 4;
  localparam int TMO     = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready;
  logic [447:0]       in_probs;
  logic [383:0]       in_vals;
  logic [63:0]        in_prior;
  logic               pe_enable, pe_advance, pe_done;
  logic [447:0]       pe_probs;
  logic [383:0]       pe_vals;
  logic [63:0]        pe_prior;
  logic [383:0]       pe_result;
  logic               out_valid, out_ready;
  logic [191:0]       out_vals;
  logic [COUNT_W-1:0] jobs_done;
  logic               timeout_err;

  int total = 0;
  int bad = 0;
  int exp_jobs = 0;
  int exp_adv = 0;
  int adv_pulses = 0;
  int overlap = 0;

  pe_sequencer #(.COUNT_W(COUNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_probs(in_probs), .in_vals(in_vals), .in_prior(in_prior),
    .pe_enable(pe_enable), .pe_advance(pe_advance), .pe_done(pe_done),
    .pe_probs(pe_probs), .pe_vals(pe_vals), .pe_prior(pe_prior),
    .pe_result(pe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_vals(out_vals),
    .jobs_done(jobs_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Passive monitor: counts advance cycles and any overlap of the two strobes.
  always @(negedge clk) begin
    if (reset) begin
      if (pe_advance) adv_pulses++;
      if (pe_enable && pe_advance) overlap++;
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full job; called at a negedge while the DUT is idle.
  task automatic applyStimulus(input int delay, input int stall, input logic [191:0] result);
    logic [511:0] r;
    logic [447:0] ep;
    logic [383:0] ev;
    logic [63:0]  epr;
    r = rnd512(); ep = r[447:0];
    r = rnd512(); ev = r[383:0];
    r = rnd512(); epr = r[63:0];
    checkOutput("in_ready_idle", 512'(in_ready), 512'(1'b1));
    in_valid = 1'b1; in_probs = ep; in_vals = ev; in_prior = epr;
    @(negedge clk);
    in_valid = 1'b0;
    r = rnd512(); in_probs = r[447:0]; in_vals = r[383:0]; in_prior = r[63:0];
    checkOutput("enable_on", 512'(pe_enable), 512'(1'b1));
    checkOutput("in_ready_busy", 512'(in_ready), 512'(1'b0));
    checkOutput("pe_probs", 512'(pe_probs), 512'(ep));
    checkOutput("pe_vals", 512'(pe_vals), 512'(ev));
    checkOutput("pe_prior", 512'(pe_prior), 512'(epr));
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      checkOutput("enable_run", 512'({pe_enable, pe_advance}), 512'(2'b10));
    end
    r = rnd512();
    pe_done = 1'b1;
    pe_result = {r[191:0], result};
    @(negedge clk);
    pe_done = 1'($urandom_range(0, 1));
    checkOutput("adv_pulse", 512'({pe_enable, pe_advance, out_valid}), 512'(3'b010));
    @(negedge clk);
    pe_done = 1'($urandom_range(0, 1));
    checkOutput("settle", 512'({pe_enable, pe_advance, out_valid}), 512'(3'b000));
    @(negedge clk);
    exp_adv++;
    checkOutput("out_valid", 512'(out_valid), 512'(1'b1));
    checkOutput("out_vals", 512'(out_vals), 512'(result));
    for (int i = 0; i < stall; i++) begin
      pe_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("hold_stable", 512'({out_valid, in_ready, out_vals}), 512'({2'b10, result}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    pe_done = 1'b0;
    exp_jobs = (exp_jobs + 1) % 16;
    checkOutput("handoff", 512'({out_valid, in_ready}), 512'(2'b01));
    checkOutput("jobs_done", 512'(jobs_done), 512'(exp_jobs));
    checkOutput("job_regs_hold", 512'({pe_prior, pe_probs}), 512'({epr, ep}));
  endtask

  initial begin
    logic [511:0] r;
    reset = 1'b0; in_valid = 1'b0; pe_done = 1'b0; out_ready = 1'b0;
    in_probs = '0; in_vals = '0; in_prior = '0; pe_result = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state",
      512'({pe_enable, pe_advance, out_valid, in_ready, timeout_err, jobs_done}),
      512'({5'b00010, 4'd0}));
    checkOutput("reset_regs", 512'({pe_prior, out_vals, pe_probs[255:0]}), 512'(0));
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(5, 0, {64'h3FD0000000000000, 64'h3FE0000000000000, 64'h3FC0000000000000});
    r = rnd512();
    applyStimulus(3, 2, r[191:0]);

    // Stray done while idle must not start anything.
    pe_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stray_done",
        512'({pe_enable, pe_advance, out_valid, in_ready, jobs_done}),
        512'({4'b0001, 4'(exp_jobs)}));
    end
    pe_done = 1'b0;

    // Reset asserted three cycles into RUN.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_run", 512'(pe_enable), 512'(1'b1));
    reset = 1'b0;
    #1;
    checkOutput("async_reset",
      512'({pe_enable, pe_advance, out_valid, in_ready, jobs_done}),
      512'({4'b0001, 4'd0}));
    checkOutput("async_reset_regs", 512'(pe_probs), 512'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_jobs = 0;
    @(negedge clk);

    // 17 jobs from a fresh counter: 1..15, 0, 1.
    for (int j = 0; j < 17; j++) begin
      r = rnd512();
      applyStimulus(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), r[191:0]);
    end

`ifdef PE_SEQ_TIMEOUT_EN
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < TMO; i++) @(negedge clk);
    checkOutput("tmo_last_run", 512'({pe_enable, timeout_err}), 512'(2'b10));
    @(negedge clk);
    checkOutput("tmo_abort",
      512'({pe_enable, pe_advance, out_valid, in_ready, timeout_err, jobs_done}),
      512'({5'b00011, 4'(exp_jobs)}));
    r = rnd512();
    applyStimulus(4, 1, r[191:0]);
    checkOutput("tmo_sticky", 512'(timeout_err), 512'(1'b1));
`else
    checkOutput("no_timeout", 512'(timeout_err), 512'(1'b0));
`endif

    checkOutput("adv_count", 512'(adv_pulses), 512'(exp_adv));
    checkOutput("strobe_overlap", 512'(overlap), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
